// File: rtl/fcmp_stage.sv
// fcmp_stage: two-stage pipelined FP compare (feq.s / flt.s / fle.s) with a
// valid/ready handshake on both sides and full backpressure.
// Optional feature macro: FCMP_IEEE_NAN_EN (IEEE NaN and signed-zero handling).
// With the macro undefined, operands compare by raw sign/magnitude.
module fcmp_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    // S1 payload registers
    logic             s1_v;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_sx1;
    logic             s1_sx2;
    logic             s1_mag_lt;
    logic             s1_mag_gt;
    logic             s1_bit_eq;
`ifdef FCMP_IEEE_NAN_EN
    logic             s1_nan;
    logic             s1_zero;
    logic             x1_nan_c;
    logic             x2_nan_c;
`endif

    // Handshake: a stage advances when the stage after it is empty or draining
    logic s2_adv_c;
    logic s1_adv_c;
    logic lt_c;
    logic eq_c;
    logic cmp_c;

    assign s2_adv_c = ~out_valid | out_ready;
    assign s1_adv_c = ~s1_v | s2_adv_c;
    assign in_ready = s1_adv_c;

`ifdef FCMP_IEEE_NAN_EN
    assign x1_nan_c = (in_x1[30:23] == 8'hFF) && (in_x1[22:0] != 23'd0);
    assign x2_nan_c = (in_x2[30:23] == 8'hFF) && (in_x2[22:0] != 23'd0);
`endif

    // Stage valid bits; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s1_adv_c) begin
                s1_v <= in_valid;
            end
            if (s2_adv_c) begin
                out_valid <= s1_v;
            end
        end
    end

    // S1 capture: sign pair, magnitude orderings and bitwise equality
    always_ff @(posedge clk) begin
        if (s1_adv_c && in_valid) begin
            s1_op     <= in_op;
            s1_tag    <= in_tag;
            s1_sx1    <= in_x1[31];
            s1_sx2    <= in_x2[31];
            s1_mag_lt <= (in_x1[30:0] < in_x2[30:0]);
            s1_mag_gt <= (in_x2[30:0] < in_x1[30:0]);
            s1_bit_eq <= (in_x1 == in_x2);
`ifdef FCMP_IEEE_NAN_EN
            s1_nan    <= x1_nan_c | x2_nan_c;
            s1_zero   <= ((in_x1[30:0] | in_x2[30:0]) == 31'd0);
`endif
        end
    end

    // S2 compare: sign/magnitude less-than, equality, op select
    always_comb begin
        lt_c  = 1'b0;
        eq_c  = s1_bit_eq;
        cmp_c = 1'b0;
        case ({s1_sx1, s1_sx2})
            2'b10:   lt_c = 1'b1;
            2'b01:   lt_c = 1'b0;
            2'b00:   lt_c = s1_mag_lt;
            2'b11:   lt_c = s1_mag_gt;
            default: lt_c = 1'b0;
        endcase
`ifdef FCMP_IEEE_NAN_EN
        // +0 and -0 are equal and neither is less than the other
        if (s1_zero) begin
            eq_c = 1'b1;
            lt_c = 1'b0;
        end
`endif
        case (s1_op)
            OP_FEQ:  cmp_c = eq_c;
            OP_FLT:  cmp_c = lt_c;
            OP_FLE:  cmp_c = lt_c | eq_c;
            default: cmp_c = 1'b0;
        endcase
`ifdef FCMP_IEEE_NAN_EN
        // Any NaN operand makes every compare false
        if (s1_nan) begin
            cmp_c = 1'b0;
        end
`endif
    end

    // S2 output registers; payload zeroed when the stage loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= 32'd0;
            out_tag  <= '0;
        end else if (s2_adv_c) begin
            out_data <= {31'd0, s1_v & cmp_c};
            out_tag  <= s1_v ? s1_tag : '0;
        end
    end

endmodule

// File: tb/tb_fcmp_stage.sv
// tb_fcmp_stage: directed vectors with hand-computed results for fcmp_stage.
// Honours FCMP_IEEE_NAN_EN for the signed-zero and NaN vectors.
module tb_fcmp_stage;

`ifdef FCMP_IEEE_NAN_EN
    localparam bit NAN_EN = 1'b1;
`else
    localparam bit NAN_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_x1;
    logic [31:0] in_x2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   out_cycs[$];
    vec_t tbl[15];

    fcmp_stage #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected result
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.d));
                check("out_tag", 64'(out_tag), 64'(e.t));
                out_cycs.push_back(cyc);
            end
        end
    end

    // Offer one op and hold it until accepted
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic r);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = tag;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 64'(in_ready), 64'd1);
        exp_q.push_back('{d: {31'd0, r}, t: tag});
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        tbl = '{
            '{2'b00, 32'hC0400000, 32'hC0400000, 1'b1},
            '{2'b10, 32'hC0400000, 32'hC0400000, 1'b1},
            '{2'b01, 32'hC0400000, 32'hC0400000, 1'b0},
            '{2'b01, 32'hC0400000, 32'hBF800000, 1'b1},
            '{2'b01, 32'h80000000, 32'h00000000, ~NAN_EN},
            '{2'b00, 32'h7FC00000, 32'h7FC00000, ~NAN_EN},
            '{2'b01, 32'hBF800000, 32'h3F800000, 1'b1},
            '{2'b11, 32'h3F800000, 32'h3F800000, 1'b0},
            '{2'b01, 32'h40000000, 32'h3F800000, 1'b0},
            '{2'b10, 32'h3F800000, 32'hBF800000, 1'b0},
            '{2'b00, 32'h80000000, 32'h00000000, NAN_EN},
            '{2'b10, 32'h80000000, 32'h00000000, 1'b1},
            '{2'b01, 32'h7FC00000, 32'h3F800000, 1'b0},
            '{2'b01, 32'h3F800000, 32'h7FC00000, ~NAN_EN},
            '{2'b10, 32'h00000000, 32'h80000000, NAN_EN}
        };

        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        in_op = 2'b00; in_x1 = 32'd0; in_x2 = 32'd0; in_tag = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Latency: FLT 1.0 < 2.0, tag 3
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 5'd3;
        @(posedge clk);
        exp_q.push_back('{d: 32'd1, t: 5'd3});
        #1 check("lat_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("lat_c2_valid", 64'(out_valid), 64'd1);
        check("lat_c2_data", 64'(out_data), 64'd1);
        check("lat_c2_tag", 64'(out_tag), 64'd3);
        drain();

        // Eight ops back-to-back must come out on eight consecutive cycles
        out_cycs.delete();
        for (int i = 0; i < 8; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 8), tbl[i].r);
        idle_in();
        drain();
        check("b2b_count", 64'(out_cycs.size()), 64'd8);
        for (int i = 1; i < out_cycs.size(); i++)
            check("b2b_gap", 64'(out_cycs[i] - out_cycs[i-1]), 64'd1);

        // Remaining directed vectors, including sign, zero and NaN corners
        for (int i = 8; i < 15; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 8), tbl[i].r);
        idle_in();
        drain();

        // Backpressure: two ops held, third stalls, output stays stable
        out_cycs.delete();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b10; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 5'd20;
        @(posedge clk);
        exp_q.push_back('{d: 32'd1, t: 5'd20});
        @(negedge clk);
        in_op = 2'b00; in_tag = 5'd21;
        @(posedge clk);
        exp_q.push_back('{d: 32'd0, t: 5'd21});
        @(negedge clk);
        in_op = 2'b01; in_tag = 5'd22;
        #1 check("bp_ready_drop", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'd1);
            check("bp_hold_tag", 64'(out_tag), 64'd20);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back('{d: 32'd1, t: 5'd22});
        idle_in();
        drain();
        check("bp_count", 64'(out_cycs.size()), 64'd3);

        // Reset with both stages full discards both ops
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 5'd30;
        @(posedge clk);
        @(negedge clk);
        in_tag = 5'd31;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("pre_rst_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        out_cycs.delete();
        repeat (6) @(negedge clk);
        check("post_rst_quiet", 64'(out_cycs.size()), 64'd0);
        check("post_rst_valid", 64'(out_valid), 64'd0);

        // Pipeline still works after reset
        send(2'b01, 32'hBF800000, 32'h3F800000, 5'd7, 1'b1);
        idle_in();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
